// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES received UART bytes into one command word, first byte in the MSBs.
// It holds a finished command until it is acknowledged and drops a partial command that stalls too long.
module uart_cmd_assembler #(
  parameter int unsigned NUM_BYTES = 3,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   frm_err
);

  localparam int unsigned CMD_W = 8 * NUM_BYTES;
  localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               frm_err_q, frm_err_d;
  logic               cap;

  // Capture is gated with rst_n so the receiver is never acknowledged during reset.
  assign cap        = rx_rdy & ~cmd_rdy_q & (state_q != FULL) & rst_n;
  assign clr_rx_rdy = cap;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frm_err    = frm_err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    frm_err_d = 1'b0;
    if (cap) begin
      cmd_d = {cmd_q[CMD_W-9:0], rx_data};
    end
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (cap) begin
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (cap) begin
          tmo_d = '0;
          if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
            cnt_d     = '0;
            cmd_rdy_d = 1'b1;
            state_d   = FULL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 2)) begin
          // The increment would reach TIMEOUT-1: abandon the partial command instead.
          cnt_d     = '0;
          tmo_d     = '0;
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FULL: begin
        tmo_d = '0;
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

endmodule
